// File: rtl/context_scheduler.sv
// Round-robin context scheduler: counts retired instructions against a quantum,
// picks the next runnable slot and sequences save / gap / restore / PC-load with the switcher.
module context_scheduler #(
    parameter int NUM_PROGS = 4,
    parameter int QUANTUM   = 256,
    parameter int WD_LIMIT  = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        instr_retired,
    input  logic        yield_req,
    input  logic [15:0] prog_active_mask,
    input  logic        cs_busy,
    input  logic [11:0] cs_restore_pc,
    input  logic        cs_restore_pc_valid,
    output logic        save_trigger,
    output logic        restore_trigger,
    output logic [3:0]  progIndex,
    output logic        cpu_stall,
    output logic        pc_load,
    output logic [11:0] pc_load_value,
    output logic [15:0] switch_count,
    output logic        cs_error
);

    typedef enum logic [2:0] {ST_RUN, ST_SAVE, ST_GAP, ST_RESTORE, ST_LOAD} state_t;

    localparam logic [15:0] QLAST  = 16'(QUANTUM - 1);
    localparam logic [15:0] WDLAST = 16'(WD_LIMIT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_qcnt;
    logic [15:0] r_wdCnt;
    logic [3:0]  r_nextProg;
    logic        r_pending;
    logic        w_candFound;
    logic [3:0]  w_candIdx;
    logic        w_request;
    logic        w_phaseDone;
    logic        w_wdExpire;
    logic        w_wdError;
    logic        w_saveNext;
    logic        w_restoreNext;
    logic        w_stallNext;
    logic        w_loadNext;

    // Descending search so the nearest slot after progIndex wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_candFound = 1'b0;
        w_candIdx   = '0;
        for (int k = NUM_PROGS - 1; k >= 1; k--) begin
            idx = int'(progIndex) + k;
            if (idx >= NUM_PROGS) idx = idx - NUM_PROGS;
            if (prog_active_mask[idx[3:0]]) begin
                w_candFound = 1'b1;
                w_candIdx   = idx[3:0];
            end
        end
    end

    // A request deferred by a busy switcher is remembered in r_pending.
    assign w_request   = enable & (yield_req | (instr_retired & (r_qcnt == QLAST)) |
                                   !prog_active_mask[progIndex] | r_pending);
    assign w_phaseDone = (r_wdCnt != 16'd0) & !cs_busy;
    assign w_wdExpire  = (r_wdCnt == WDLAST);
    assign w_wdError   = ((r_state == ST_SAVE) || (r_state == ST_RESTORE)) & !w_phaseDone & w_wdExpire;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_RUN;
            save_trigger    <= 1'b0;
            restore_trigger <= 1'b0;
            cpu_stall       <= 1'b0;
            pc_load         <= 1'b0;
        end else begin
            r_state         <= w_nextState;
            save_trigger    <= w_saveNext;
            restore_trigger <= w_restoreNext;
            cpu_stall       <= w_stallNext;
            pc_load         <= w_loadNext;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RUN:     if (w_request && w_candFound && !cs_busy) w_nextState = ST_SAVE;
            ST_SAVE:    if (w_phaseDone) w_nextState = ST_GAP;
                        else if (w_wdExpire) w_nextState = ST_RUN;
            ST_GAP:     w_nextState = ST_RESTORE;
            ST_RESTORE: if (w_phaseDone) w_nextState = ST_LOAD;
                        else if (w_wdExpire) w_nextState = ST_RUN;
            ST_LOAD:    w_nextState = ST_RUN;
            default:    w_nextState = ST_RUN;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        w_saveNext    = (w_nextState == ST_SAVE);
        w_restoreNext = (w_nextState == ST_RESTORE);
        w_loadNext    = (w_nextState == ST_LOAD);
        w_stallNext   = (w_nextState != ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_qcnt        <= '0;
            r_wdCnt       <= '0;
            r_nextProg    <= '0;
            r_pending     <= 1'b0;
            progIndex     <= '0;
            pc_load_value <= '0;
            switch_count  <= '0;
            cs_error      <= 1'b0;
        end else begin
            if ((r_state == ST_SAVE) || (r_state == ST_RESTORE)) r_wdCnt <= r_wdCnt + 16'd1;
            else r_wdCnt <= '0;
            case (r_state)
                ST_RUN: begin
                    if (!enable) begin
                        r_qcnt    <= '0;
                        r_pending <= 1'b0;
                    end else if (w_request) begin
                        r_qcnt    <= '0;
                        r_pending <= w_candFound & cs_busy;
                        if (w_candFound && !cs_busy) r_nextProg <= w_candIdx;
                    end else if (instr_retired) begin
                        r_qcnt <= r_qcnt + 16'd1;
                    end
                end
                ST_GAP:     progIndex <= r_nextProg;
                ST_RESTORE: if (cs_restore_pc_valid) pc_load_value <= cs_restore_pc;
                ST_LOAD:    switch_count <= switch_count + 16'd1;
                default:    ;
            endcase
            if (w_wdError) cs_error <= 1'b1;
        end
    end

endmodule

// File: doc/context_scheduler.md
# context_scheduler

Round-robin program scheduler that initiates processor context switches. It counts retired instructions against a time quantum and picks the next loaded program slot. It then runs the handshake that drives the context switcher: save the current program, release, restore the next program. Finally it stalls the CPU and loads the restored PC. It sits between the CPU control path and the context switcher, and owns `progIndex`.

## Interface
- `NUM_PROGS`, default 4: number of program slots scheduled, 1..16; slot s is valid only if s < NUM_PROGS.
- `QUANTUM`, default 256: retired instructions per time slice, 1..65535.
- `WD_LIMIT`, default 255: cycles allowed per save/restore phase before a watchdog error is raised.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  scheduling enabled; when low, no switch is started.
- `instr_retired`  in  1  one-cycle pulse per completed CPU instruction.
- `yield_req`  in  1  voluntary switch request (syscall); sampled in RUN only.
- `prog_active_mask`  in  16  bit s = slot s holds a runnable program.
- `cs_busy`  in  1  context switcher busy.
- `cs_restore_pc`  in  12  PC restored by the context switcher.
- `cs_restore_pc_valid`  in  1  qualifies `cs_restore_pc`.
- `save_trigger`  out  1  level request to save the current slot.
- `restore_trigger`  out  1  level request to restore a slot.
- `progIndex`  out  4  slot addressed by the context switcher; this is the running program.
- `cpu_stall`  out  1  freezes CPU fetch and retire.
- `pc_load`  out  1  one-cycle strobe: CPU PC ← `pc_load_value`.
- `pc_load_value`  out  12  PC to load.
- `switch_count`  out  16  completed switches, wraps at 0xFFFF→0.
- `cs_error`  out  1  sticky watchdog error.

## Operation
- States: RUN, SAVE, GAP, RESTORE, LOAD. All outputs are registered.
- RUN:
  - The quantum counter `qcnt` increments on `instr_retired` when `enable`=1. It is held at 0 when `enable`=0.
  - Switch request = `enable` & (`yield_req` | (`instr_retired` & `qcnt`==QUANTUM-1) | !`prog_active_mask[progIndex]`).
  - Candidate = first slot with its mask bit set, searching `progIndex`+1, +2, … modulo NUM_PROGS and excluding `progIndex`.
  - With no candidate, no switch is made and `qcnt` is cleared.
  - With a candidate and `cs_busy`=0: latch `next_prog`, clear `qcnt`, go to SAVE with `save_trigger`=1 and `cpu_stall`=1.
  - If `cs_busy`=1, the request is deferred; it is re-evaluated every cycle.
- SAVE:
  - `save_trigger` is held high and `progIndex` is unchanged.
  - The first SAVE cycle is ignored. On any later cycle with `cs_busy`=0, drop `save_trigger` and go to GAP.
- GAP, exactly one cycle:
  - Both triggers are low, so the switcher clears its done flag.
  - `progIndex` ← `next_prog`. Go to RESTORE with `restore_trigger`=1.
- RESTORE:
  - `restore_trigger` is held high.
  - A cycle with `cs_restore_pc_valid`=1 captures `pc_load_value` ← `cs_restore_pc`.
  - The first RESTORE cycle is ignored. On any later cycle with `cs_busy`=0, drop `restore_trigger` and go to LOAD.
- LOAD, one cycle:
  - `pc_load`=1 and `cpu_stall` stays 1.
  - `switch_count` increments. Go to RUN.
- Watchdog:
  - A phase counter clears on entry to SAVE and to RESTORE.
  - If it reaches WD_LIMIT before `cs_busy` falls: set `cs_error`, drop both triggers, and return to RUN with stall released.
  - `progIndex` is unchanged if the error occurs in SAVE. It is already `next_prog` if the error occurs in RESTORE.
  - No `pc_load` is issued.
- Simultaneous events:
  - `yield_req` together with quantum expiry gives one switch.
  - Changes to `enable` or `prog_active_mask` after leaving RUN do not abort a switch in flight.
  - `instr_retired` outside RUN is ignored.
- Reset, also mid-switch: state RUN, all triggers 0, `progIndex`=0, `cpu_stall`=0, `pc_load`=0, `pc_load_value`=0, `qcnt`=0, `switch_count`=0, `cs_error`=0.

## Timing
- Decision cycle T is in RUN. At T+1, `save_trigger`=1 and `cpu_stall`=1.
  - The instruction retiring at T counts. The CPU must not retire at T+1 or later.
- `cs_busy` must first fall at cycle S ≥ T+2. At S+1, `save_trigger`=0 (GAP).
- At S+2, `restore_trigger`=1 and `progIndex`=`next_prog`.
- `cs_busy` must first fall at cycle R ≥ S+3. At R+1, `pc_load`=1 (LOAD).
- At R+2, the state is RUN with `cpu_stall`=0.
- Scheduler overhead beyond switcher latency: 4 cycles.
- `progIndex` is stable throughout every trigger-high interval.

## Test plan
- QUANTUM=4, mask=0b0011, slot 0 running:
  - Stimulus: 4 `instr_retired` pulses, switcher model returning PC 0x123.
  - Required: `save_trigger` with `progIndex`=0, one GAP cycle, `restore_trigger` with `progIndex`=1, `pc_load`=1 with value 0x123, `switch_count`=1, stall released 1 cycle later.
- mask=0b1001, NUM_PROGS=4, slot 3 running, `yield_req`:
  - Required: wrap-around to `progIndex`=0.
  - Repeat with mask=0b1000: no switch, `qcnt` cleared, `cpu_stall` stays 0.
- `yield_req` and quantum expiry in the same cycle:
  - Required: exactly one `save_trigger` assertion and `switch_count`+1.
- Switcher model holding `cs_busy`=1 forever in SAVE, WD_LIMIT=16:
  - Required: `cs_error`=1 after 16 cycles, triggers 0, RUN state, `progIndex` unchanged, no `pc_load`.
- `cs_busy`=1 at the decision cycle:
  - Required: switch deferred until `cs_busy`=0, then it proceeds normally.
- `reset` asserted during RESTORE:
  - Required: next cycle all outputs at reset values, `progIndex`=0, `switch_count`=0.
  - `enable`=0 afterwards: no switch after 1000 `instr_retired` pulses.
